// File: rtl/pipe_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_seq_pkg
// Purpose  : Shared types and limits for the pipeline sequencer block.
//            Holds the sequencer state encoding and the legal parameter
//            ranges.
// Contents : seq_state_e          - 3-bit sequencer state encoding
//            c_NUM_STAGES_MIN/MAX - legal NUM_STAGES range
//            c_FETCH_LAT_MIN/MAX  - legal FETCH_LAT range
//            c_FILL_CNT_W         - width of the FILL down-counter
// Revision : 1.0 - initial release
// ============================================================================
package pipe_seq_pkg;

    typedef enum logic [2:0] {
        BOOT  = 3'd0,
        FILL  = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        IDLE  = 3'd4
    } seq_state_e;

    localparam int c_NUM_STAGES_MIN = 2;
    localparam int c_NUM_STAGES_MAX = 8;
    localparam int c_FETCH_LAT_MIN  = 1;
    localparam int c_FETCH_LAT_MAX  = 4;

    // The counter must be able to hold the largest legal FETCH_LAT value.
    localparam int c_FILL_CNT_W     = $clog2(c_FETCH_LAT_MAX + 1);

endpackage : pipe_seq_pkg
`default_nettype wire

// File: rtl/pipe_valid_shifter.sv
`default_nettype none
// ============================================================================
// Module   : pipe_valid_shifter
// Purpose  : Holds the per-stage valid bits of the pipeline. Each enabled
//            stage loads the valid bit of the stage behind it; a stalled
//            stage keeps its own bit and feeds a bubble forward. A flush
//            kills every stage up to and including FLUSH_STAGE on the next
//            edge, while the branch in FLUSH_STAGE itself moves on.
// Ports    : clk         - clock, rising edge
//            rst_n       - asynchronous active-low reset
//            stage_en    - per-stage register enable
//            issue       - new instruction enters stage 0
//            flush       - kill the wrong-path stages
//            stage_valid - current valid vector
// Revision : 1.0 - initial release
// ============================================================================
module pipe_valid_shifter
    import pipe_seq_pkg::*;
#(
    parameter int NUM_STAGES  = 4,
    parameter int FLUSH_STAGE = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_STAGES-1:0] stage_en,
    input  logic                  issue,
    input  logic                  flush,
    output logic [NUM_STAGES-1:0] stage_valid
);

    logic [NUM_STAGES-1:0] r_valid;
    logic [NUM_STAGES-1:0] w_next;

    always_comb begin
        w_next    = '0;
        w_next[0] = issue;
        // A stage whose predecessor is stalled receives a bubble.
        for (int i = 1; i < NUM_STAGES; i++) begin
            w_next[i] = stage_en[i-1] & r_valid[i-1];
        end
        // Everything younger than the branch is wrong-path; the slot the
        // branch vacates is cleared too, since it refills from stage below.
        if (flush) begin
            for (int i = 0; i <= FLUSH_STAGE; i++) begin
                w_next[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
        end else begin
            for (int i = 0; i < NUM_STAGES; i++) begin
                if (stage_en[i]) begin
                    r_valid[i] <= w_next[i];
                end
            end
        end
    end

    assign stage_valid = r_valid;

endmodule : pipe_valid_shifter
`default_nettype wire

// File: rtl/pipeline_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_sequencer
// Purpose  : Control sequencer for an in-order pipeline. Boots the PC,
//            waits out the fetch latency, issues instructions into stage 0,
//            handles load-use stalls, branch flushes and halt/drain/resume.
// Ports    : clk, rst_n    - clock (rising) / async active-low reset
//            hazard_stall  - stage 0 cannot accept an operand this cycle
//            flush         - taken branch resolved in FLUSH_STAGE
//            halt_req      - stop issuing and drain
//            go            - leave the halted state
//            load_pc       - PC register load strobe (boot only)
//            sel_pc_boot   - PC mux selects the boot vector
//            issue         - fetch word enters stage 0 this edge
//            stage_en      - per-stage register enable
//            stage_valid   - per-stage valid bit
//            halted        - pipeline empty and idle
//            seq_state     - current state (seq_state_e encoding)
//            cyc_cnt, stall_cnt, flush_cnt - 32-bit performance counters,
//                            present only when PIPE_SEQ_PERF_EN is defined
// Macro    : PIPE_SEQ_PERF_EN - enables the performance counters
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_sequencer
    import pipe_seq_pkg::*;
#(
    parameter int NUM_STAGES  = 4,
    parameter int FETCH_LAT   = 2,
    parameter int FLUSH_STAGE = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  hazard_stall,
    input  logic                  flush,
    input  logic                  halt_req,
    input  logic                  go,
    output logic                  load_pc,
    output logic                  sel_pc_boot,
    output logic                  issue,
    output logic [NUM_STAGES-1:0] stage_en,
    output logic [NUM_STAGES-1:0] stage_valid,
    output logic                  halted,
    output logic [2:0]            seq_state
`ifdef PIPE_SEQ_PERF_EN
    ,
    output logic [31:0]           cyc_cnt,
    output logic [31:0]           stall_cnt,
    output logic [31:0]           flush_cnt
`endif
);

    localparam logic [c_FILL_CNT_W-1:0] c_FILL_LOAD = c_FILL_CNT_W'(FETCH_LAT);

    seq_state_e              r_state;
    logic [c_FILL_CNT_W-1:0] r_fill_cnt;
    logic                    r_load_pc;
    logic                    r_sel_pc_boot;
    logic                    r_halted;

    logic                    w_flush_act;
    logic                    w_stall;
    logic                    w_issue;
    logic [NUM_STAGES-1:0]   w_stage_en;
    logic [NUM_STAGES-1:0]   w_stage_valid;

    // A flush only matters while instructions may be in flight.
    assign w_flush_act = flush &&
                         ((r_state == FILL) || (r_state == RUN) || (r_state == DRAIN));

    // Flush wins over a stall: the stalled operand is wrong-path anyway.
    assign w_stall = (r_state == RUN) && hazard_stall && !flush;

    assign w_issue = (r_state == RUN) && !hazard_stall && !flush && !halt_req;

    assign w_stage_en = (r_state == IDLE) ? '0
                                          : {{(NUM_STAGES-1){1'b1}}, ~w_stall};

    // ------------------------------------------------------------------
    // Sequencer FSM. BOOT is held through reset with load_pc low; the
    // first edge after reset raises load_pc, the second moves to FILL, so
    // exactly one cycle carries the boot-vector load.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= BOOT;
            r_fill_cnt    <= '0;
            r_load_pc     <= 1'b0;
            r_sel_pc_boot <= 1'b0;
            r_halted      <= 1'b0;
        end else begin
            r_load_pc     <= 1'b0;
            r_sel_pc_boot <= 1'b0;
            r_halted      <= 1'b0;
            unique case (r_state)
                BOOT: begin
                    if (!r_load_pc) begin
                        r_load_pc     <= 1'b1;
                        r_sel_pc_boot <= 1'b1;
                    end else begin
                        r_state    <= FILL;
                        r_fill_cnt <= c_FILL_LOAD;
                    end
                end
                FILL: begin
                    if (w_flush_act) begin
                        r_fill_cnt <= c_FILL_LOAD;
                    end else if (halt_req) begin
                        r_state    <= DRAIN;
                        r_fill_cnt <= '0;
                    end else if (r_fill_cnt <= c_FILL_CNT_W'(1)) begin
                        r_state    <= RUN;
                        r_fill_cnt <= '0;
                    end else begin
                        r_fill_cnt <= r_fill_cnt - 1'b1;
                    end
                end
                RUN: begin
                    if (w_flush_act) begin
                        r_state    <= FILL;
                        r_fill_cnt <= c_FILL_LOAD;
                    end else if (halt_req) begin
                        r_state    <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (w_stage_valid == '0) begin
                        r_state  <= IDLE;
                        r_halted <= 1'b1;
                    end
                end
                IDLE: begin
                    // Resume from the current PC: no load_pc here.
                    if (go) begin
                        r_state    <= FILL;
                        r_fill_cnt <= c_FILL_LOAD;
                    end else begin
                        r_halted <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= BOOT;
                    r_fill_cnt <= '0;
                end
            endcase
        end
    end

    pipe_valid_shifter #(
        .NUM_STAGES  (NUM_STAGES),
        .FLUSH_STAGE (FLUSH_STAGE)
    ) u_valid_shifter (
        .clk         (clk),
        .rst_n       (rst_n),
        .stage_en    (w_stage_en),
        .issue       (w_issue),
        .flush       (w_flush_act),
        .stage_valid (w_stage_valid)
    );

    assign load_pc     = r_load_pc;
    assign sel_pc_boot = r_sel_pc_boot;
    assign issue       = w_issue;
    assign stage_en    = w_stage_en;
    assign stage_valid = w_stage_valid;
    assign halted      = r_halted;
    assign seq_state   = r_state;

`ifdef PIPE_SEQ_PERF_EN
    logic [31:0] r_cyc_cnt;
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    // Free-running counters; natural 32-bit wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cyc_cnt   <= '0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_cyc_cnt <= r_cyc_cnt + 32'd1;
            if (w_stall) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (w_flush_act) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
        end
    end

    assign cyc_cnt   = r_cyc_cnt;
    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`endif

endmodule : pipeline_sequencer
`default_nettype wire

// File: tb/tb_pipeline_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_sequencer
// Purpose  : Self-checking bench for pipeline_sequencer (NUM_STAGES=4,
//            FETCH_LAT=2, FLUSH_STAGE=1). A cycle table covers boot, fill,
//            issue latency, stall bubbles, flush, flush+stall, halt/drain,
//            resume and flush+halt; hand sequences cover asynchronous reset
//            mid-operation and, with PIPE_SEQ_PERF_EN, the counters.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_sequencer;
    import pipe_seq_pkg::*;

    localparam int c_NS = 4;
    localparam int c_NV = 38;

    logic            clk;
    logic            rst_n;
    logic            hazard_stall;
    logic            flush;
    logic            halt_req;
    logic            go;
    logic            load_pc;
    logic            sel_pc_boot;
    logic            issue;
    logic [c_NS-1:0] stage_en;
    logic [c_NS-1:0] stage_valid;
    logic            halted;
    logic [2:0]      seq_state;
`ifdef PIPE_SEQ_PERF_EN
    logic [31:0]     cyc_cnt;
    logic [31:0]     stall_cnt;
    logic [31:0]     flush_cnt;
`endif

    int r_tests;
    int r_fails;

    pipeline_sequencer #(
        .NUM_STAGES  (c_NS),
        .FETCH_LAT   (2),
        .FLUSH_STAGE (1)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .hazard_stall (hazard_stall),
        .flush        (flush),
        .halt_req     (halt_req),
        .go           (go),
        .load_pc      (load_pc),
        .sel_pc_boot  (sel_pc_boot),
        .issue        (issue),
        .stage_en     (stage_en),
        .stage_valid  (stage_valid),
        .halted       (halted),
        .seq_state    (seq_state)
`ifdef PIPE_SEQ_PERF_EN
        ,
        .cyc_cnt      (cyc_cnt),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic            hz, fl, ht, go;
        logic            ld, sel, iss;
        logic [c_NS-1:0] en, vld;
        logic            hlt;
        logic [2:0]      st;
    } vec_t;

    vec_t vecs[c_NV];

    function automatic vec_t mk(input logic hz, fl, ht, g, ld, sel, iss,
                                input logic [3:0] en, vld,
                                input logic hlt, input logic [2:0] st);
        vec_t v;
        v.hz = hz; v.fl = fl; v.ht = ht; v.go = g;
        v.ld = ld; v.sel = sel; v.iss = iss;
        v.en = en; v.vld = vld; v.hlt = hlt; v.st = st;
        return v;
    endfunction

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        r_tests++;
        if (got !== exp) begin
            r_fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] pack_dut();
        return {1'b0, load_pc, sel_pc_boot, issue, stage_en, stage_valid, halted, seq_state};
    endfunction

    initial begin
        r_tests = 0;
        r_fails = 0;

        // Each row describes one cycle: inputs driven in that cycle and the
        // outputs expected during it. Row 0 is the first cycle after the
        // first clock edge following reset release.
        //            hz fl ht go ld se is  en     vld   hlt state
        vecs[0]  = mk(0, 0, 0, 0, 1, 1, 0, 4'hF, 4'h0, 0, BOOT);
        vecs[1]  = mk(0, 0, 0, 0, 0, 0, 0, 4'hF, 4'h0, 0, FILL);
        vecs[2]  = mk(0, 0, 0, 0, 0, 0, 0, 4'hF, 4'h0, 0, FILL);
        vecs[3]  = mk(0, 0, 0, 0, 0, 0, 1, 4'hF, 4'h0, 0, RUN);
        vecs[4]  = mk(0, 0, 0, 0, 0, 0, 1, 4'hF, 4'h1, 0, RUN);
        vecs[5]  = mk(0, 0, 0, 0, 0, 0, 1, 4'hF, 4'h3, 0, RUN);
        vecs[6]  = mk(0, 0, 0, 0, 0, 0, 1, 4'hF, 4'h7, 0, RUN);
        vecs[7]  = mk(1, 0, 0, 0, 0, 0, 0, 4'hE, 4'hF, 0, RUN);  // stall 1
        vecs[8]  = mk(1, 0, 0, 0, 0, 0, 0, 4'hE, 4'hD, 0, RUN);  // stall 2
        vecs[9]  = mk(0, 0, 0, 0, 0, 0, 1, 4'hF, 4'h9, 0, RUN);
        vecs[10] = mk(0, 0, 0, 0, 0, 0, 1, 4'hF, 4'h3, 0, RUN);  // bubble @3
        vecs[11] = mk(0, 0, 0, 0, 0, 0, 1, 4'hF, 4'h7, 0, RUN);  // bubble @3
        vecs[12] = mk(0, 1, 0, 0, 0, 0, 0, 4'hF, 4'hF, 0, RUN);  // flush
        vecs[13] = mk(0, 0, 0, 0, 0, 0, 0, 4'hF, 4'hC, 0, FILL);
        vecs[14] = mk(0, 0, 0, 0, 0, 0, 0, 4'hF, 4'h8, 0, FILL);
        vecs[15] = mk(0, 0, 0, 0, 0, 0, 1, 4'hF, 4'h0, 0, RUN);
        vecs[16] = mk(0, 0, 0, 0, 0, 0, 1, 4'hF, 4'h1, 0, RUN);
        vecs[17] = mk(1, 1, 0, 0, 0, 0, 0, 4'hF, 4'h3, 0, RUN);  // flush+stall
        vecs[18] = mk(0, 0, 0, 0, 0, 0, 0, 4'hF, 4'h4, 0, FILL);
        vecs[19] = mk(0, 0, 0, 0, 0, 0, 0, 4'hF, 4'h8, 0, FILL);
        vecs[20] = mk(0, 0, 0, 0, 0, 0, 1, 4'hF, 4'h0, 0, RUN);
        vecs[21] = mk(0, 0, 0, 0, 0, 0, 1, 4'hF, 4'h1, 0, RUN);
        vecs[22] = mk(0, 0, 0, 0, 0, 0, 1, 4'hF, 4'h3, 0, RUN);
        vecs[23] = mk(0, 0, 0, 0, 0, 0, 1, 4'hF, 4'h7, 0, RUN);
        vecs[24] = mk(0, 0, 1, 0, 0, 0, 0, 4'hF, 4'hF, 0, RUN);  // halt
        vecs[25] = mk(0, 0, 0, 0, 0, 0, 0, 4'hF, 4'hE, 0, DRAIN);
        vecs[26] = mk(0, 0, 0, 0, 0, 0, 0, 4'hF, 4'hC, 0, DRAIN);
        vecs[27] = mk(0, 0, 0, 0, 0, 0, 0, 4'hF, 4'h8, 0, DRAIN);
        vecs[28] = mk(0, 0, 0, 0, 0, 0, 0, 4'hF, 4'h0, 0, DRAIN);
        vecs[29] = mk(0, 0, 0, 0, 0, 0, 0, 4'h0, 4'h0, 1, IDLE);
        vecs[30] = mk(0, 0, 0, 1, 0, 0, 0, 4'h0, 4'h0, 1, IDLE); // go
        vecs[31] = mk(0, 0, 0, 0, 0, 0, 0, 4'hF, 4'h0, 0, FILL);
        vecs[32] = mk(0, 0, 0, 0, 0, 0, 0, 4'hF, 4'h0, 0, FILL);
        vecs[33] = mk(0, 0, 0, 0, 0, 0, 1, 4'hF, 4'h0, 0, RUN);
        vecs[34] = mk(0, 1, 1, 0, 0, 0, 0, 4'hF, 4'h1, 0, RUN);  // flush+halt
        vecs[35] = mk(0, 0, 1, 0, 0, 0, 0, 4'hF, 4'h0, 0, FILL); // halt resampled
        vecs[36] = mk(0, 0, 0, 0, 0, 0, 0, 4'hF, 4'h0, 0, DRAIN);
        vecs[37] = mk(0, 0, 0, 0, 0, 0, 0, 4'h0, 4'h0, 1, IDLE);

        rst_n        = 1'b0;
        hazard_stall = 1'b0;
        flush        = 1'b0;
        halt_req     = 1'b0;
        go           = 1'b0;

        repeat (2) tick();
        check("reset_state", {7'd0, load_pc, issue, halted, stage_valid, seq_state},
              {7'd0, 1'b0, 1'b0, 1'b0, 4'h0, 3'(BOOT)});
        rst_n = 1'b1;

        for (int k = 0; k < c_NV; k++) begin
            @(posedge clk);
            #1;
            hazard_stall = vecs[k].hz;
            flush        = vecs[k].fl;
            halt_req     = vecs[k].ht;
            go           = vecs[k].go;
            #1;
            check($sformatf("vec%0d", k), pack_dut(),
                  {1'b0, vecs[k].ld, vecs[k].sel, vecs[k].iss, vecs[k].en,
                   vecs[k].vld, vecs[k].hlt, vecs[k].st});
        end

        // Resume, issue two words, then reset asynchronously mid-cycle.
        tick();
        hazard_stall = 1'b0; flush = 1'b0; halt_req = 1'b0;
        go = 1'b1;
        tick();
        go = 1'b0;
        repeat (4) tick();
        check("pre_reset_valid", {12'd0, stage_valid}, {12'd0, 4'h3});
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", {7'd0, load_pc, issue, halted, stage_valid, seq_state},
              {7'd0, 1'b0, 1'b0, 1'b0, 4'h0, 3'(BOOT)});
        tick();
        rst_n = 1'b1;
        tick();
        check("reboot_load_pc", {12'd0, load_pc, sel_pc_boot, seq_state[1:0]},
              {12'd0, 1'b1, 1'b1, 2'd0});
        repeat (3) tick();
        check("reboot_run", {13'd0, seq_state}, {13'd0, 3'(RUN)});

        // Ten RUN cycles with three stalls and a closing flush.
        for (int j = 0; j < 10; j++) begin
            hazard_stall = (j == 1) || (j == 3) || (j == 5);
            flush        = (j == 9);
            tick();
        end
        hazard_stall = 1'b0;
        flush        = 1'b0;
        check("post_flush_state", {13'd0, seq_state}, {13'd0, 3'(FILL)});
`ifdef PIPE_SEQ_PERF_EN
        check("stall_cnt", stall_cnt[15:0], 16'd3);
        check("flush_cnt", flush_cnt[15:0], 16'd1);
        check("cyc_cnt", cyc_cnt[15:0], 16'd14);
`endif

        $display("[TB] %0d tests run, %0d failed", r_tests, r_fails);
        $finish;
    end

endmodule : tb_pipeline_sequencer
`default_nettype wire
